pixel_sink_queue: RTL and testbench
===================================

// Module: pixel_sink_queue
// PURPOSE
//   Consumer end of the pixel-coordinate stream produced by the graph/shape plotters.
//   Accepts (x, y, colour) beats, clips off-screen pixels and buffers beats in a FIFO.
//   Presents one pixel at a time to the VGA adapter port, with a linear framebuffer address.
//   Sits between the plotter mux and vga_adapter; absorbs bursts while the adapter port is stalled.
// PARAMETERS
//   FIFO_DEPTH  16   entries; power of 2, >= 2
//   X_MAX       320  screen width; x >= X_MAX is off-screen
//   Y_MAX       240  screen height; y >= Y_MAX is off-screen
//   COLOUR_W    3    colour bits per pixel
// PORTS
//   clk         in   1         rising-edge clock
//   reset       in   1         synchronous, active-high
//   in_valid    in   1         input beat present
//   in_ready    out  1         = !full && !reset; beat accepted on edge when in_valid&&in_ready
//   in_x        in   9         pixel x
//   in_y        in   8         pixel y
//   in_colour   in   COLOUR_W  pixel colour
//   in_last     in   1         final beat of a drawing (e.g. bar complete)
//   out_x       out  9         registered pixel x
//   out_y       out  8         registered pixel y
//   out_addr    out  17        y*X_MAX + x, registered with out_x/out_y
//   out_colour  out  COLOUR_W  registered colour
//   out_plot    out  1         pixel valid to adapter; held until out_ready
//   out_ready   in   1         adapter takes pixel on edge when out_plot&&out_ready
//   frame_done  out  1         1-cycle pulse: last-marked entry retired
//   clip_count  out  8         off-screen beats dropped; saturates at 255
//   level       out  clog2(FIFO_DEPTH)+1  current FIFO occupancy
// BEHAVIOUR
//   Reset: FIFO pointers/level=0, out_plot=0, out_x/out_y/out_addr/out_colour=0, frame_done=0, clip_count=0, in_ready=0.
//     Reset mid-operation discards all queued and presented pixels; no frame_done is emitted.
//   Entry = {x, y, colour, last, vis}. vis=1 iff in_x<X_MAX && in_y<Y_MAX.
//   Accept with vis=0 and last=0: beat not written; clip_count++ (saturating).
//   Accept with vis=0 and last=1: written as a marker entry (no plot); clip_count++.
//   Accept with vis=1: entry written.
//   Full: in_ready=0 even if a pop occurs the same cycle; no write-through when full.
//   Pop condition (edge): level!=0 && (!out_plot || out_ready).
//     Popped vis=1 entry loads the out_* registers; out_plot=1 after that edge.
//     Popped marker entry leaves out_* unchanged; out_plot=0 after the edge; frame_done pulses next cycle.
//     No pop and out_plot&&out_ready: out_plot=0.
//   Latency, empty queue and idle output: beat accepted at edge N; out_plot=1 after edge N+1. No bypass.
//   Throughput: 1 pixel/cycle with out_ready held high.
//   frame_done=1 for exactly one cycle after either event:
//     (a) the edge where a presented pixel with last=1 is taken (out_plot&&out_ready); or
//     (b) the edge where a marker entry is popped.
//   Stable outputs: out_x/out_y/out_addr/out_colour stay constant while out_plot && !out_ready.
//   Address: out_addr = out_y*X_MAX + out_x, computed from the popped entry in the pop cycle. Unsigned, 17 bits, no overflow in range.
//   Simultaneous push+pop: level unchanged; pointers wrap modulo FIFO_DEPTH.
//   level counts marker entries as well as pixel entries.
// TESTING
//   1 In-range stream: beats (0,0),(319,239),(8,100), out_ready=1 -> out_plot one cycle after each accept;
//     out_addr 0, 76799, 32008; level returns to 0.
//   2 Clipping: beats (320,5),(5,240),(400,0) -> no out_plot; clip_count=3; level=0.
//     Next 300 clipped beats -> clip_count saturates at 255.
//   3 Backpressure: out_ready=0 and 17 beats offered, DEPTH=16 -> 16 queued (level=16), 1 presented, in_ready=0;
//     out_* stable; out_ready=1 then drains all 17 in order, 1 per cycle.
//   4 frame_done: 8x3 bar with last on final beat -> single frame_done pulse one cycle after final pixel taken.
//     Clipped last beat (330,10) -> pulse one cycle after marker pops, no out_plot.
//   5 Mid-burst reset: queue 5 pixels, out_ready=0, assert reset 1 cycle -> out_plot=0, level=0,
//     clip_count=0, no frame_done; next beat after reset appears 2 edges after accept.
//   6 Full boundary: level=16, in_valid=1, out_ready=1 -> pop occurs, no push that cycle; push accepted next cycle.

Source files
------------

// File: rtl/pixel_sink_queue.sv
// pixel_sink_queue: clips off-screen plotter beats, queues the rest and presents them one at a time to the VGA adapter
module pixel_sink_queue #(
  parameter int FIFO_DEPTH = 16,
  parameter int X_MAX = 320,
  parameter int Y_MAX = 240,
  parameter int COLOUR_W = 3,
  localparam int AW = $clog2(FIFO_DEPTH)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [8:0]          in_x,
  input  logic [7:0]          in_y,
  input  logic [COLOUR_W-1:0] in_colour,
  input  logic                in_last,
  output logic [8:0]          out_x,
  output logic [7:0]          out_y,
  output logic [16:0]         out_addr,
  output logic [COLOUR_W-1:0] out_colour,
  output logic                out_plot,
  input  logic                out_ready,
  output logic                frame_done,
  output logic [7:0]          clip_count,
  output logic [AW:0]         level
);
  typedef struct packed {
    logic [8:0]          x;
    logic [7:0]          y;
    logic [COLOUR_W-1:0] colour;
    logic                last;
    logic                vis;
  } entry_t;
  localparam logic [AW:0] DEPTH_L = (AW+1)'(FIFO_DEPTH);
  entry_t mem [FIFO_DEPTH];
  entry_t head;
  logic [AW-1:0] wptr, rptr;
  logic vis, accept, push, pop, out_last;
  logic [16:0] head_addr;
  assign in_ready = (level != DEPTH_L) && !reset;
  assign vis = (32'(in_x) < X_MAX) && (32'(in_y) < Y_MAX);
  assign accept = in_valid && in_ready;
  // Off-screen beats are dropped unless they carry the end-of-drawing marker
  assign push = accept && (vis || in_last);
  assign pop = (level != '0) && (!out_plot || out_ready);
  assign head = mem[rptr];
  assign head_addr = 17'(head.y) * 17'(X_MAX) + 17'(head.x);
  always_ff @(posedge clk)
    if (push) mem[wptr] <= '{x: in_x, y: in_y, colour: in_colour, last: in_last, vis: vis};
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
      level <= '0;
      out_x <= '0;
      out_y <= '0;
      out_addr <= '0;
      out_colour <= '0;
      out_plot <= 1'b0;
      out_last <= 1'b0;
      frame_done <= 1'b0;
      clip_count <= '0;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (pop) rptr <= rptr + AW'(1);
      level <= level + (AW+1)'(push) - (AW+1)'(pop);
      if (pop && head.vis) begin
        out_x <= head.x;
        out_y <= head.y;
        out_addr <= head_addr;
        out_colour <= head.colour;
        out_last <= head.last;
        out_plot <= 1'b1;
      end else if (pop || out_ready) out_plot <= 1'b0;
      frame_done <= (out_plot && out_ready && out_last) || (pop && !head.vis);
      if (accept && !vis && clip_count != 8'hff) clip_count <= clip_count + 8'd1;
    end
  end
endmodule

// File: tb/tb_pixel_sink_queue.sv
// tb_pixel_sink_queue: directed checks of clipping, queueing, backpressure and frame_done
module tb_pixel_sink_queue;
  logic clk = 1'b0, reset = 1'b1, in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b1;
  logic [8:0] in_x = '0, out_x;
  logic [7:0] in_y = '0, out_y, clip_count;
  logic [2:0] in_colour = '0, out_colour;
  logic [16:0] out_addr;
  logic in_ready, out_plot, frame_done;
  logic [4:0] level;
  int tests = 0, fails = 0;

  pixel_sink_queue dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_x(in_x), .in_y(in_y), .in_colour(in_colour), .in_last(in_last),
    .out_x(out_x), .out_y(out_y), .out_addr(out_addr), .out_colour(out_colour),
    .out_plot(out_plot), .out_ready(out_ready), .frame_done(frame_done),
    .clip_count(clip_count), .level(level)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input int x, input int y, input int c, input logic last);
    in_valid = 1'b1;
    in_x = 9'(x);
    in_y = 8'(y);
    in_colour = 3'(c);
    in_last = last;
  endtask

  initial begin
    tick;
    tick;
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_out_plot", 32'(out_plot), 0);
    chk("rst_level", 32'(level), 0);
    chk("rst_clip", 32'(clip_count), 0);
    chk("rst_frame_done", 32'(frame_done), 0);
    chk("rst_out_addr", 32'(out_addr), 0);
    reset = 1'b0;
    tick;
    chk("idle_in_ready", 32'(in_ready), 1);

    // in-range stream
    drive(0, 0, 1, 1'b0);
    tick;
    chk("t1_level_after_accept", 32'(level), 1);
    chk("t1_no_bypass", 32'(out_plot), 0);
    drive(319, 239, 2, 1'b0);
    tick;
    chk("t1_plot0", 32'(out_plot), 1);
    chk("t1_addr0", 32'(out_addr), 0);
    chk("t1_colour0", 32'(out_colour), 1);
    drive(8, 100, 3, 1'b0);
    tick;
    chk("t1_addr1", 32'(out_addr), 76799);
    chk("t1_x1", 32'(out_x), 319);
    chk("t1_y1", 32'(out_y), 239);
    in_valid = 1'b0;
    tick;
    chk("t1_addr2", 32'(out_addr), 32008);
    chk("t1_colour2", 32'(out_colour), 3);
    chk("t1_level_empty", 32'(level), 0);
    tick;
    chk("t1_plot_drop", 32'(out_plot), 0);

    // clipping
    drive(320, 5, 1, 1'b0);
    tick;
    drive(5, 240, 1, 1'b0);
    tick;
    drive(400, 0, 1, 1'b0);
    tick;
    in_valid = 1'b0;
    tick;
    chk("t2_clip3", 32'(clip_count), 3);
    chk("t2_level", 32'(level), 0);
    chk("t2_no_plot", 32'(out_plot), 0);
    drive(500, 250, 0, 1'b0);
    for (int i = 0; i < 300; i++) tick;
    in_valid = 1'b0;
    tick;
    chk("t2_clip_sat", 32'(clip_count), 255);
    chk("t2_level_sat", 32'(level), 0);

    // backpressure: 17 beats with the adapter stalled
    out_ready = 1'b0;
    for (int i = 0; i < 17; i++) begin
      drive(i, i + 1, i % 8, 1'b0);
      tick;
    end
    in_valid = 1'b0;
    chk("t3_level_full", 32'(level), 16);
    chk("t3_in_ready_full", 32'(in_ready), 0);
    chk("t3_plot_held", 32'(out_plot), 1);
    chk("t3_x_first", 32'(out_x), 0);
    tick;
    tick;
    chk("t3_x_stable", 32'(out_x), 0);
    chk("t3_addr_stable", 32'(out_addr), 320);
    chk("t3_plot_stable", 32'(out_plot), 1);

    // full boundary: pop happens, the offered beat waits one cycle
    out_ready = 1'b1;
    drive(100, 0, 5, 1'b0);
    chk("t6_in_ready_full", 32'(in_ready), 0);
    tick;
    chk("t6_level_pop_only", 32'(level), 15);
    chk("t6_x1", 32'(out_x), 1);
    chk("t6_in_ready_next", 32'(in_ready), 1);
    tick;
    in_valid = 1'b0;
    chk("t6_level_push_pop", 32'(level), 15);
    chk("t6_x2", 32'(out_x), 2);
    for (int i = 3; i < 17; i++) begin
      tick;
      chk($sformatf("t3_drain_x%0d", i), 32'(out_x), 32'(i));
      chk($sformatf("t3_drain_addr%0d", i), 32'(out_addr), 32'((i + 1) * 320 + i));
    end
    tick;
    chk("t6_late_x", 32'(out_x), 100);
    chk("t6_late_addr", 32'(out_addr), 100);
    chk("t6_late_colour", 32'(out_colour), 5);
    tick;
    chk("t3_drained_plot", 32'(out_plot), 0);
    chk("t3_drained_level", 32'(level), 0);

    // frame_done on an 8x3 bar
    for (int y = 20; y < 23; y++)
      for (int x = 10; x < 18; x++) begin
        drive(x, y, 6, (x == 17 && y == 22));
        tick;
        chk("t4_no_early_done", 32'(frame_done), 0);
      end
    in_valid = 1'b0;
    in_last = 1'b0;
    tick;
    chk("t4_last_presented", 32'(out_plot), 1);
    chk("t4_last_x", 32'(out_x), 17);
    chk("t4_last_addr", 32'(out_addr), 22 * 320 + 17);
    chk("t4_done_not_yet", 32'(frame_done), 0);
    tick;
    chk("t4_done_pulse", 32'(frame_done), 1);
    chk("t4_plot_off", 32'(out_plot), 0);
    tick;
    chk("t4_done_single", 32'(frame_done), 0);

    // clipped last beat becomes a marker entry
    drive(330, 10, 2, 1'b1);
    tick;
    in_valid = 1'b0;
    in_last = 1'b0;
    chk("t4_marker_level", 32'(level), 1);
    chk("t4_marker_no_plot", 32'(out_plot), 0);
    tick;
    chk("t4_marker_done", 32'(frame_done), 1);
    chk("t4_marker_no_plot2", 32'(out_plot), 0);
    chk("t4_marker_x_kept", 32'(out_x), 17);
    chk("t4_marker_level0", 32'(level), 0);
    tick;
    chk("t4_marker_done_single", 32'(frame_done), 0);

    // reset in the middle of a burst
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(i + 1, 7, 4, (i == 4));
      tick;
    end
    in_valid = 1'b0;
    in_last = 1'b0;
    chk("t5_level_before", 32'(level), 4);
    reset = 1'b1;
    tick;
    chk("t5_plot", 32'(out_plot), 0);
    chk("t5_level", 32'(level), 0);
    chk("t5_clip", 32'(clip_count), 0);
    chk("t5_in_ready_rst", 32'(in_ready), 0);
    reset = 1'b0;
    out_ready = 1'b1;
    tick;
    chk("t5_no_done", 32'(frame_done), 0);
    chk("t5_no_plot", 32'(out_plot), 0);
    drive(50, 60, 7, 1'b0);
    tick;
    in_valid = 1'b0;
    chk("t5_accept_level", 32'(level), 1);
    chk("t5_accept_no_plot", 32'(out_plot), 0);
    tick;
    chk("t5_plot_after2", 32'(out_plot), 1);
    chk("t5_addr", 32'(out_addr), 19250);
    tick;
    chk("t5_final_done", 32'(frame_done), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
